// File: rtl/nn_pkg.sv
`default_nettype none
//==============================================================================
// Module      : nn_pkg
// Description : Shared constants and the loader state encoding for the input
//               vector loader and its pixel packer.
// Revision    : 1.0 - initial release
//==============================================================================
package nn_pkg;

    localparam int PIX_W   = 16;
    localparam int NUM_PIX = 10;

    // Loader sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        START  = 3'd4,
        RUN    = 3'd5,
        DONE   = 3'd6
    } state_t;

    // A run is in progress in every state other than IDLE and DONE.
    function automatic logic is_busy(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/input_vec_loader_pix_packer.sv
`default_nettype none
//==============================================================================
// Module      : pix_packer
// Description : Lane counter plus insert register. Each accepted pixel is
//               written into the slice selected by the lane counter; word_full
//               flags the acceptance of the last lane.
// Revision    : 1.0 - initial release
//==============================================================================
module pix_packer #(
    parameter int PIX_W   = 16,
    parameter int NUM_PIX = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     pix_ready,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [NUM_PIX*PIX_W-1:0] word_data,
    output logic                     word_full
);

    localparam int LANE_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(NUM_PIX - 1);

    logic [LANE_W-1:0]        r_lane;
    logic [NUM_PIX*PIX_W-1:0] r_data;
    logic                     w_accept;

    assign w_accept  = pix_valid & pix_ready;
    assign word_full = w_accept && (r_lane == c_last_lane);
    assign word_data = r_data;

    // Lane counter: restarts on a new run and after the last lane is taken.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lane <= '0;
        end else if (w_accept) begin
            if (r_lane == c_last_lane) begin
                r_lane <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    // Word register: only the addressed lane changes, so the word stays stable
    // between fills and is consumed by the SRAM during WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data[int'(r_lane)*PIX_W +: PIX_W] <= pix_data;
        end
    end

endmodule : pix_packer
`default_nettype wire

// File: rtl/input_vec_loader.sv
`default_nettype none
//==============================================================================
// Module      : input_vec_loader
// Description : Collects a serial pixel stream into 10-lane SRAM words, writes
//               each word, waits for SRAM read latency, then starts the compute
//               core and waits for it before loading the next vector.
// Revision    : 1.0 - initial release
//==============================================================================
module input_vec_loader #(
    parameter int PIX_W      = nn_pkg::PIX_W,
    parameter int NUM_PIX    = nn_pkg::NUM_PIX,
    parameter int NUM_VEC    = 100,
    parameter int VEC_W      = 7,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     sram_we,
    output logic [NUM_PIX*PIX_W-1:0] sram_data,
    output logic                     nn_start,
    input  logic                     nn_done,
    output logic [VEC_W-1:0]         vec_idx,
    output logic                     busy,
    output logic                     all_done
);

    import nn_pkg::*;

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] c_vec_last    = VEC_W'(NUM_VEC - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [VEC_W-1:0] r_vec_idx;
    logic             r_pix_ready;
    logic             r_sram_we;
    logic             r_nn_start;
    logic             r_busy;
    logic             r_all_done;
    logic             w_word_full;
    logic             w_run_start;
    logic             w_vec_adv;

    assign pix_ready = r_pix_ready;
    assign sram_we   = r_sram_we;
    assign nn_start  = r_nn_start;
    assign vec_idx   = r_vec_idx;
    assign busy      = r_busy;
    assign all_done  = r_all_done;

    pix_packer #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_run_start),
        .pix_ready (r_pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .word_data (sram_data),
        .word_full (w_word_full)
    );

    // Next-state decode; go and nn_done only matter in the states that sample them.
    always_comb begin
        w_next      = r_state;
        w_run_start = 1'b0;
        w_vec_adv   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (go) begin
                    w_next      = FILL;
                    w_run_start = 1'b1;
                end
            end
            FILL: begin
                if (w_word_full) w_next = WRITE;
            end
            WRITE:  w_next = SETTLE;
            SETTLE: begin
                if (r_settle_cnt == c_settle_last) w_next = START;
            end
            START:  w_next = RUN;
            RUN: begin
                if (nn_done) begin
                    if (r_vec_idx == c_vec_last) begin
                        w_next = DONE;
                    end else begin
                        w_next    = FILL;
                        w_vec_adv = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so every
    // output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_vec_idx    <= '0;
            r_pix_ready  <= 1'b0;
            r_sram_we    <= 1'b0;
            r_nn_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_all_done   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + 1'b1 : '0;
            r_pix_ready  <= (w_next == FILL);
            r_sram_we    <= (w_next == WRITE);
            r_nn_start   <= (w_next == START);
            r_busy       <= is_busy(w_next);
            r_all_done   <= (w_next == DONE);
            if (w_run_start) begin
                r_vec_idx <= '0;
            end else if (w_vec_adv) begin
                r_vec_idx <= r_vec_idx + 1'b1;
            end
        end
    end

endmodule : input_vec_loader
`default_nettype wire

// File: tb/tb_input_vec_loader.sv
`default_nettype none
//==============================================================================
// Module      : tb_input_vec_loader
// Description : Directed self-checking bench. One loader built for a single
//               vector per run, one for three vectors; both see the same inputs.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_input_vec_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic         pix_valid = 1'b0;
    logic [15:0]  pix_data = '0;
    logic         nn_done = 1'b0;

    logic         pix_ready1, sram_we1, nn_start1, busy1, all_done1;
    logic [159:0] sram_data1;
    logic [6:0]   vec_idx1;
    logic         pix_ready3, sram_we3, nn_start3, busy3, all_done3;
    logic [159:0] sram_data3;
    logic [6:0]   vec_idx3;

    int checks = 0;
    int failures = 0;
    int we1 = 0, st1 = 0, we3 = 0, st3 = 0;
    int w0, s0;
    logic [15:0]  word;
    logic [159:0] exp_data;

    always #5 clk = ~clk;

    input_vec_loader #(.NUM_VEC(1), .VEC_W(7)) u_one (
        .clk(clk), .rst(rst), .go(go), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready1), .sram_we(sram_we1), .sram_data(sram_data1),
        .nn_start(nn_start1), .nn_done(nn_done), .vec_idx(vec_idx1),
        .busy(busy1), .all_done(all_done1)
    );

    input_vec_loader #(.NUM_VEC(3), .VEC_W(7)) u_three (
        .clk(clk), .rst(rst), .go(go), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready3), .sram_we(sram_we3), .sram_data(sram_data3),
        .nn_start(nn_start3), .nn_done(nn_done), .vec_idx(vec_idx3),
        .busy(busy3), .all_done(all_done3)
    );

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (sram_we1)  we1 <= we1 + 1;
        if (nn_start1) st1 <= st1 + 1;
        if (sram_we3)  we3 <= we3 + 1;
        if (nn_start3) st3 <= st3 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; pix_valid = 1'b0; nn_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        #1;
        // ---------------- reset / idle ----------------
        do_reset();
        repeat (5) tick();
        chk("rst_pix_ready", 160'(pix_ready1), 160'(0));
        chk("rst_sram_we",   160'(sram_we1),   160'(0));
        chk("rst_nn_start",  160'(nn_start1),  160'(0));
        chk("rst_busy",      160'(busy1),      160'(0));
        chk("rst_all_done",  160'(all_done1),  160'(0));
        chk("rst_vec_idx",   160'(vec_idx1),   160'(0));
        chk("rst_sram_data", sram_data1,       160'(0));

        // ---------------- single vector (NUM_VEC=1) ----------------
        w0 = we1; s0 = st1;
        pulse_go();
        chk("sv_pix_ready", 160'(pix_ready1), 160'(1));
        chk("sv_busy",      160'(busy1),      160'(1));
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1; pix_data = 16'(i + 1);
            tick();
        end
        pix_valid = 1'b0;
        chk("sv_we",        160'(sram_we1),   160'(1));
        chk("sv_data",      sram_data1, 160'h000A_0009_0008_0007_0006_0005_0004_0003_0002_0001);
        chk("sv_ready_off", 160'(pix_ready1), 160'(0));
        tick();
        chk("sv_we_off",    160'(sram_we1),   160'(0));
        chk("sv_start_e1",  160'(nn_start1),  160'(0));
        tick();
        chk("sv_start_e2",  160'(nn_start1),  160'(0));
        tick();
        chk("sv_start",     160'(nn_start1),  160'(1));
        tick();
        chk("sv_start_off", 160'(nn_start1),  160'(0));
        chk("sv_run_busy",  160'(busy1),      160'(1));
        repeat (3) tick();
        nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        chk("sv_all_done",  160'(all_done1),  160'(1));
        chk("sv_busy_off",  160'(busy1),      160'(0));
        chk("sv_vec_idx",   160'(vec_idx1),   160'(0));
        tick();
        chk("sv_we_count",    160'(we1 - w0), 160'(1));
        chk("sv_start_count", 160'(st1 - s0), 160'(1));

        // ---------------- stalled stream ----------------
        do_reset();
        w0 = we1;
        pulse_go();
        for (int i = 0; i < 19; i++) begin
            if (i % 2 == 0) begin
                pix_valid = 1'b1; pix_data = 16'(i / 2 + 1);
            end else begin
                pix_valid = 1'b0; pix_data = 16'hDEAD;
            end
            tick();
        end
        chk("st_we",   160'(sram_we1), 160'(1));
        chk("st_data", sram_data1, 160'h000A_0009_0008_0007_0006_0005_0004_0003_0002_0001);
        pix_valid = 1'b1; pix_data = 16'hBEEF;
        repeat (3) tick();
        pix_valid = 1'b0;
        chk("st_data_hold", sram_data1, 160'h000A_0009_0008_0007_0006_0005_0004_0003_0002_0001);
        chk("st_start",     160'(nn_start1), 160'(1));
        tick();
        chk("st_we_count",  160'(we1 - w0), 160'(1));

        // ---------------- multi-vector (NUM_VEC=3) ----------------
        do_reset();
        w0 = we3; s0 = st3;
        pulse_go();
        for (int v = 0; v < 3; v++) begin
            chk("mv_vec_idx", 160'(vec_idx3),   160'(v));
            chk("mv_ready",   160'(pix_ready3), 160'(1));
            word = 16'((v + 1) * 16'h1111);
            for (int i = 0; i < 10; i++) begin
                pix_valid = 1'b1; pix_data = word;
                tick();
            end
            pix_valid = 1'b0;
            exp_data = {10{word}};
            chk("mv_we",    160'(sram_we3), 160'(1));
            chk("mv_data",  sram_data3, exp_data);
            repeat (3) tick();
            chk("mv_start", 160'(nn_start3), 160'(1));
            repeat (3) tick();
            nn_done = 1'b1;
            tick();
            nn_done = 1'b0;
        end
        chk("mv_all_done", 160'(all_done3), 160'(1));
        chk("mv_busy_off", 160'(busy3),     160'(0));
        chk("mv_idx_last", 160'(vec_idx3),  160'(2));
        tick();
        chk("mv_we_count",    160'(we3 - w0), 160'(3));
        chk("mv_start_count", 160'(st3 - s0), 160'(3));
        pulse_go();
        chk("mv_restart_idx",  160'(vec_idx3),   160'(0));
        chk("mv_restart_done", 160'(all_done3),  160'(0));
        chk("mv_restart_busy", 160'(busy3),      160'(1));
        chk("mv_restart_rdy",  160'(pix_ready3), 160'(1));

        // ---------------- spurious controls ----------------
        do_reset();
        s0 = st3;
        pulse_go();
        nn_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1; pix_data = 16'(16'h0100 + i);
            tick();
        end
        pix_valid = 1'b0;
        chk("sp_we",       160'(sram_we3), 160'(1));
        chk("sp_idx_fill", 160'(vec_idx3), 160'(0));
        repeat (3) tick();
        chk("sp_start",    160'(nn_start3), 160'(1));
        tick();
        nn_done = 1'b0;
        chk("sp_run_busy",  160'(busy3),      160'(1));
        chk("sp_run_idx",   160'(vec_idx3),   160'(0));
        chk("sp_run_ready", 160'(pix_ready3), 160'(0));
        go = 1'b1;
        repeat (2) tick();
        go = 1'b0;
        chk("sp_go_start", 160'(nn_start3),  160'(0));
        chk("sp_go_ready", 160'(pix_ready3), 160'(0));
        chk("sp_go_idx",   160'(vec_idx3),   160'(0));
        nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        chk("sp_adv_idx",   160'(vec_idx3),   160'(1));
        chk("sp_adv_ready", 160'(pix_ready3), 160'(1));
        chk("sp_start_count", 160'(st3 - s0), 160'(1));

        // ---------------- reset mid-fill ----------------
        do_reset();
        w0 = we3;
        pulse_go();
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1; pix_data = 16'(16'h5000 + i);
            tick();
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rm_ready", 160'(pix_ready3), 160'(0));
        chk("rm_busy",  160'(busy3),      160'(0));
        chk("rm_data",  sram_data3,       160'(0));
        rst = 1'b0;
        tick();
        chk("rm_no_we", 160'(we3 - w0), 160'(0));
        pulse_go();
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1; pix_data = 16'(16'hA000 + i);
            tick();
        end
        pix_valid = 1'b0;
        chk("rm_we",   160'(sram_we3), 160'(1));
        chk("rm_data_new", sram_data3, 160'hA009_A008_A007_A006_A005_A004_A003_A002_A001_A000);
        tick();
        chk("rm_we_count", 160'(we3 - w0), 160'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_vec_loader
`default_nettype wire
